// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: one shared round datapath stepped through all ten rounds.
// Optional feature macro: AES_SEQ_ABORT_EN adds a synchronous abort input that cancels an in-flight block.
module aes_round_sequencer (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
`ifdef AES_SEQ_ABORT_EN
    input  logic         abort,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [3:0]   round_idx
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]   fsm;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [3:0]   rc_q;
    logic [127:0] key_next;
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic         abort_req;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // RoundKeyGenerator: next 128-bit round key from the current one and the round-constant index.
    function automatic logic [127:0] round_key(input logic [3:0] rc, input logic [127:0] k);
        logic [31:0] temp;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] n2;
        logic [31:0] n3;
        temp = sub_word({k[23:0], k[31:24]}) ^ {rcon(rc), 24'h000000};
        n0   = k[127:96] ^ temp;
        n1   = k[95:64] ^ n0;
        n2   = k[63:32] ^ n1;
        n3   = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[i*8 +: 8] = sub_byte(s[i*8 +: 8]);
        end
        return o;
    endfunction

    // Bytes are column-major: byte r+4c is row r of column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(15 - (r + 4*c))*8 +: 8] = s[(15 - (r + 4*((c + r) % 4)))*8 +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[(3 - c)*32 +: 32] = mix_column(s[(3 - c)*32 +: 32]);
        end
        return o;
    endfunction

`ifdef AES_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign key_next = round_key(rc_q, key_q);
    assign sb       = sub_bytes(state_q);
    assign sr       = shift_rows(sb);
    assign mc       = mix_columns(sr);

    // The final round skips MixColumns and writes straight into the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= ST_IDLE;
            state_q    <= '0;
            key_q      <= '0;
            rc_q       <= 4'd0;
            ciphertext <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q <= plaintext ^ key;
                        key_q   <= key;
                        rc_q    <= 4'd1;
                        fsm     <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (abort_req) begin
                        rc_q <= 4'd0;
                        fsm  <= ST_IDLE;
                    end else begin
                        state_q <= mc ^ key_next;
                        key_q   <= key_next;
                        rc_q    <= rc_q + 4'd1;
                        if (rc_q == 4'd9) begin
                            fsm <= ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    if (!abort_req) begin
                        ciphertext <= sr ^ key_next;
                        fsm        <= ST_DONE;
                    end else begin
                        fsm <= ST_IDLE;
                    end
                    rc_q <= 4'd0;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        fsm <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm == ST_IDLE);
    assign out_valid = (fsm == ST_DONE);
    assign busy      = (fsm == ST_ROUND) || (fsm == ST_FINAL);
    assign round_idx = rc_q;

endmodule
